// File: rtl/tl_host_request_arbiter.sv
// Round-robin arbiter sharing the UART-to-TileLink bridge packet port, with a credit limit and an owner FIFO
// that steers Ch D responses back to their requester. Define TL_ARB_TIMEOUT_EN to build the response timeout.
module tl_host_request_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 65536,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_data,
   output logic                   packet_valid,
   input  logic                   packet_ready,
   output logic [127:0]           packet_data,
   input  logic                   rsp_valid,
   output logic                   rsp_owner_valid,
   output logic [IDW-1:0]         rsp_owner,
   output logic [CW-1:0]          outstanding,
   output logic                   rsp_unexpected,
   output logic                   timeout_err
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUTSTANDING);
   localparam logic [IDW-1:0] LAST_REQ = IDW'(NUM_REQ - 1);

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   win_q, win_d;
   logic [IDW-1:0]   rr_last_q, rr_last_d;
   logic [127:0]     packet_data_q, packet_data_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rsp_unexpected_q, rsp_unexpected_d;
   logic [IDW-1:0]   owner_mem_q [MAX_OUTSTANDING];
   logic [IDW-1:0]   owner_mem_d [MAX_OUTSTANDING];

   int               cand;
   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic             grant;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             rsp_pop;
   logic             timeout_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (int'(p) == MAX_OUTSTANDING - 1) return '0;
      return p + PW'(1);
   endfunction

   // Rotating priority: scan starts one past the last winner and wraps modulo NUM_REQ.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      cand        = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(rr_last_q) + k) % NUM_REQ;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

   assign fifo_empty = (count_q == '0);
   assign grant      = (state_q == S_IDLE) && grant_found && (count_q < MAX_CNT);
   assign push       = (state_q == S_HOLD) && packet_ready;
   assign rsp_pop    = rsp_valid && !fifo_empty;
   assign pop        = rsp_pop || timeout_pop;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      rr_last_d     = rr_last_q;
      packet_data_d = packet_data_q;
      if (grant) begin
         state_d       = S_HOLD;
         win_d         = grant_idx;
         rr_last_d     = grant_idx;
         packet_data_d = req_data[int'(grant_idx)*128 +: 128];
      end else if (push) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      owner_mem_d = owner_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         owner_mem_d[wr_ptr_q] = win_q;
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      // Push and pop together leave the in-flight count untouched.
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      rsp_unexpected_d = rsp_unexpected_q | (rsp_valid & fifo_empty);
   end

   always_ff @(posedge sysclk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
      if (reset) begin
         state_q          <= S_IDLE;
         win_q            <= '0;
         rr_last_q        <= LAST_REQ;
         packet_data_q    <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         rsp_unexpected_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         win_q            <= win_d;
         rr_last_q        <= rr_last_d;
         packet_data_q    <= packet_data_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         rsp_unexpected_q <= rsp_unexpected_d;
      end
   end

   // NOTE: the owner storage has no reset; entries are only read between a push and its pop, and the pointers are reset.
   always_ff @(posedge sysclk) begin
      owner_mem_q <= owner_mem_d;
   end

`ifdef TL_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          timeout_err_q, timeout_err_d;

   // A response arriving in the expiry cycle wins; the stale head is only dropped when nothing came back.
   always_comb begin
      timeout_pop = 1'b0;
      to_cnt_d    = to_cnt_q + TW'(1);
      if (rsp_valid || fifo_empty) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
         timeout_pop = 1'b1;
         to_cnt_d    = '0;
      end
      timeout_err_d = timeout_err_q | timeout_pop;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_pop = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign packet_valid    = (state_q == S_HOLD);
   assign packet_data     = packet_data_q;
   assign rsp_owner_valid = rsp_pop;
   assign rsp_owner       = owner_mem_q[rd_ptr_q];
   assign outstanding     = count_q;
   assign rsp_unexpected  = rsp_unexpected_q;

endmodule

// File: tb/tb_tl_host_request_arbiter.sv
// Scoreboard bench for tl_host_request_arbiter: a queue-based reference model predicts each cycle's
// outputs and a negedge monitor compares them against the DUT.
module tb_tl_host_request_arbiter;

   localparam int N    = 3;
   localparam int MAXO = 4;
   localparam int IDW  = 2;
   localparam int CW   = 3;

   logic                 sysclk;
   logic                 reset;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N*128-1:0]     req_data;
   logic                 packet_valid;
   logic                 packet_ready;
   logic [127:0]         packet_data;
   logic                 rsp_valid;
   logic                 rsp_owner_valid;
   logic [IDW-1:0]       rsp_owner;
   logic [CW-1:0]        outstanding;
   logic                 rsp_unexpected;
   logic                 timeout_err;

   tl_host_request_arbiter #(
      .NUM_REQ         (N),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .sysclk          (sysclk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .packet_valid    (packet_valid),
      .packet_ready    (packet_ready),
      .packet_data     (packet_data),
      .rsp_valid       (rsp_valid),
      .rsp_owner_valid (rsp_owner_valid),
      .rsp_owner       (rsp_owner),
      .outstanding     (outstanding),
      .rsp_unexpected  (rsp_unexpected),
      .timeout_err     (timeout_err)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   typedef struct {
      logic [N-1:0]   ready;
      logic           pv;
      logic [127:0]   pdata;
      logic           ov;
      logic [IDW-1:0] owner;
      logic [CW-1:0]  outst;
      logic           unexp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: a held packet, the last winner, and a queue of in-flight owners.
   bit           m_hold;
   int           m_win;
   logic [127:0] m_data;
   int           m_rr;
   int           m_q[$];
   bit           m_unexp;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*128-1:0] rand_data();
      logic [N*128-1:0] r;
      for (int i = 0; i < N*4; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_hold  = 1'b0;
      m_win   = 0;
      m_data  = '0;
      m_rr    = N - 1;
      m_q.delete();
      m_unexp = 1'b0;
   endtask

   // Predict the outputs of the current cycle from the inputs just driven, then advance the model.
   task automatic model_cycle();
      exp_t e;
      int   w;
      bit   granted;
      e.ready = '0;
      e.pv    = m_hold;
      e.pdata = m_data;
      e.ov    = 1'b0;
      e.owner = '0;
      e.outst = CW'(m_q.size());
      e.unexp = m_unexp;
      granted = 1'b0;
      w       = 0;
      if (!m_hold && req_valid != '0 && m_q.size() < MAXO) begin
         for (int k = 1; k <= N; k++) begin
            if (!granted && req_valid[(m_rr + k) % N]) begin
               w       = (m_rr + k) % N;
               granted = 1'b1;
            end
         end
         e.ready[w] = 1'b1;
      end
      if (rsp_valid) begin
         if (m_q.size() > 0) begin
            e.ov    = 1'b1;
            e.owner = IDW'(m_q.pop_front());
         end else begin
            m_unexp = 1'b1;
         end
      end
      if (m_hold && packet_ready) begin
         m_q.push_back(m_win);
         m_hold = 1'b0;
      end
      if (granted) begin
         m_hold = 1'b1;
         m_win  = w;
         m_rr   = w;
         m_data = req_data[128*w +: 128];
      end
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [N-1:0] rv, input logic [N*128-1:0] d, input logic pr, input logic rsp);
      @(posedge sysclk);
      #1;
      req_valid    = rv;
      req_data     = d;
      packet_ready = pr;
      rsp_valid    = rsp;
      model_cycle();
   endtask

   task automatic do_reset(input int cycles);
      @(posedge sysclk);
      #1;
      reset        = 1'b1;
      req_valid    = '0;
      packet_ready = 1'b0;
      rsp_valid    = 1'b0;
      repeat (cycles) @(posedge sysclk);
      #1;
      reset = 1'b0;
      model_reset();
      model_cycle();
      check("reset_packet_data", packet_data, 128'h0);
   endtask

   // Finish any held packet and return every in-flight response.
   task automatic drain();
      for (int i = 0; i < 4 * MAXO && (m_hold || m_q.size() > 0); i++)
         step('0, rand_data(), 1'b1, m_q.size() > 0);
   endtask

   exp_t mon_e;
   always @(negedge sysclk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("req_ready", req_ready, mon_e.ready);
         check("packet_valid", packet_valid, mon_e.pv);
         if (mon_e.pv) check("packet_data", packet_data, mon_e.pdata);
         check("rsp_owner_valid", rsp_owner_valid, mon_e.ov);
         if (mon_e.ov) check("rsp_owner", rsp_owner, mon_e.owner);
         check("outstanding", outstanding, mon_e.outst);
         check("rsp_unexpected", rsp_unexpected, mon_e.unexp);
         check("timeout_err", timeout_err, 1'b0);
      end
   end

   logic [N*128-1:0] dd;

   initial begin
      reset        = 1'b1;
      req_valid    = '0;
      req_data     = '0;
      packet_ready = 1'b0;
      rsp_valid    = 1'b0;
      model_reset();
      do_reset(3);

      // Single request from requester 0 with a fixed payload.
      dd = '0;
      dd[127:0] = {16{8'hA5}};
      step(3'b001, dd, 1'b1, 1'b0);
      step(3'b000, dd, 1'b1, 1'b0);
      step(3'b000, dd, 1'b1, 1'b0);
      drain();

      // Fairness between requesters 0 and 1, responses echoed after each accept.
      dd[255:128] = {16{8'h5A}};
      for (int i = 0; i < 12; i++) step(3'b011, dd, 1'b1, m_q.size() > 0);
      drain();

      // Credit stall with no responses, then a single response frees one credit.
      for (int i = 0; i < 12; i++) step(3'b001, rand_data(), 1'b1, 1'b0);
      step(3'b011, rand_data(), 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(3'b011, rand_data(), 1'b1, 1'b0);
      drain();

      // Backpressure: packet held for 10 cycles with other requesters waiting.
      step(3'b010, rand_data(), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(3'b111, rand_data(), 1'b0, 1'b0);
      step(3'b111, rand_data(), 1'b1, 1'b0);
      drain();

      // Simultaneous push and pop with two already in flight.
      for (int i = 0; i < 4; i++) step(3'b100, rand_data(), 1'b1, 1'b0);
      step(3'b100, rand_data(), 1'b1, 1'b0);
      step(3'b000, rand_data(), 1'b1, 1'b1);
      step(3'b000, rand_data(), 1'b1, 1'b0);
      drain();

      // Unexpected response with nothing in flight.
      step(3'b000, rand_data(), 1'b0, 1'b1);
      step(3'b000, rand_data(), 1'b0, 1'b0);

      // Reset while a packet is held drops it and clears the sticky flag.
      step(3'b001, rand_data(), 1'b0, 1'b0);
      step(3'b000, rand_data(), 1'b0, 1'b0);
      do_reset(2);
      step(3'b110, rand_data(), 1'b1, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++)
         step(N'($urandom), rand_data(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4));
      drain();

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge sysclk);
      @(negedge sysclk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
